ps2_frame_rx: RTL and testbench

System-clock-domain PS/2 receive front end for the keyboard path. It samples the raw keyboard clock and data pins, filters glitches and checks start, odd parity and stop bits. It folds the 0xE0 (extended) and 0xF0 (break) prefix bytes into flags, then delivers one clean scancode per key event with a single-cycle valid strobe. The downstream command decoder turns these scancodes into clr/add/sub/disp/load instructions.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_line_filter.sv | 49 ++++
 rtl/ps2_frame_rx.sv | 138 +++++++++++++
 tb/tb_ps2_frame_rx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard-path definitions: receive FSM states, prefix bytes and
// the command scancodes consumed by the downstream decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam logic [7:0] CLR  = 8'h70;
  localparam logic [7:0] ADD  = 8'h69;
  localparam logic [7:0] SUB  = 8'h72;
  localparam logic [7:0] DISP = 8'h7A;
  localparam logic [7:0] LOAD = 8'h6B;

  // Odd parity: the 8 data bits plus the parity bit must hold an odd number of ones.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes a raw PS/2 line, debounces it with a run-length filter and
// emits a one-cycle pulse on each filtered 1->0 transition.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_fall
);

  localparam int CW = $clog2(FILTER_LEN);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_fall;
  logic          w_synced;
  logic          w_flip;

  assign w_synced = r_sync[1];
  // The level flips on the FILTER_LEN-th consecutive opposite sample.
  assign w_flip   = (w_synced != r_level) && (r_cnt == CW'(FILTER_LEN - 1));

  always_ff @(posedge i_clk) begin
    // NOTE: the synchronizer resets to the idle-high line level so that reset
    // release can never look like a falling clock edge.
    if (!i_rst_n) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_fall <= w_flip && r_level;
      if (w_flip) begin
        r_level <= w_synced;
        r_cnt   <= '0;
      end else if (w_synced != r_level) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_fall = r_fall;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 receive front end: frames 11-bit keyboard words, checks start/parity/stop,
// folds E0/F0 prefixes into flags and strobes out one scancode per key event.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_code,
  output logic       o_code_valid,
  output logic       o_is_break,
  output logic       o_is_extended,
  output logic       o_parity_err,
  output logic       o_frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [1:0]  r_data_sync;
  ps2_state_e  r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_parity;
  logic        r_pend_break;
  logic        r_pend_ext;
  logic [TW-1:0] r_tmo;
  logic [7:0]  r_code;
  logic        r_code_valid;
  logic        r_is_break;
  logic        r_is_extended;
  logic        r_parity_err;
  logic        r_frame_err;
  logic        w_event;
  logic        w_data;
  logic        w_tmo_hit;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_line  (i_ps2_clk),
    .o_fall  (w_event)
  );

  assign w_data = r_data_sync[1];
  // r_tmo counts cycles since the last bit event (event cycle = 0); the abort
  // registers in the same edge that would take it to TIMEOUT_CYCLES-1.
  assign w_tmo_hit = (r_state != ST_IDLE) && (r_tmo == TW'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_data_sync   <= 2'b11;
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_parity      <= 1'b0;
      r_pend_break  <= 1'b0;
      r_pend_ext    <= 1'b0;
      r_tmo         <= '0;
      r_code        <= '0;
      r_code_valid  <= 1'b0;
      r_is_break    <= 1'b0;
      r_is_extended <= 1'b0;
      r_parity_err  <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_data_sync  <= {r_data_sync[0], i_ps2_data};
      // NOTE: strobes default low every cycle so each one lasts exactly one cycle.
      r_code_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;

      if (w_tmo_hit) begin
        r_state      <= ST_IDLE;
        r_frame_err  <= 1'b1;
        r_pend_break <= 1'b0;
        r_pend_ext   <= 1'b0;
        r_tmo        <= '0;
      end else begin
        if (w_event)                r_tmo <= TW'(1);
        else if (r_state == ST_IDLE) r_tmo <= '0;
        else                        r_tmo <= r_tmo + TW'(1);

        if (w_event) begin
          case (r_state)
            ST_IDLE: begin
              if (!w_data) begin
                r_state   <= ST_DATA;
                r_bit_cnt <= '0;
              end
            end
            ST_DATA: begin
              r_shift   <= {w_data, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
            end
            ST_PARITY: begin
              r_parity <= w_data;
              r_state  <= ST_STOP;
            end
            ST_STOP: begin
              r_state <= ST_IDLE;
              if (!w_data || !ps2_parity_ok(r_shift, r_parity)) begin
                r_frame_err  <= !w_data;
                r_parity_err <= w_data;
                r_pend_break <= 1'b0;
                r_pend_ext   <= 1'b0;
              end else if (r_shift == PS2_BREAK) begin
                r_pend_break <= 1'b1;
              end else if (r_shift == PS2_EXT) begin
                r_pend_ext <= 1'b1;
              end else begin
                r_code        <= r_shift;
                r_is_break    <= r_pend_break;
                r_is_extended <= r_pend_ext;
                r_code_valid  <= 1'b1;
                r_pend_break  <= 1'b0;
                r_pend_ext    <= 1'b0;
              end
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign o_code        = r_code;
  assign o_code_valid  = r_code_valid;
  assign o_is_break    = r_is_break;
  assign o_is_extended = r_is_extended;
  assign o_parity_err  = r_parity_err;
  assign o_frame_err   = r_frame_err;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Scoreboard bench for ps2_frame_rx: a frame-level model queues expected events,
// an independent monitor pops and compares them whenever the DUT strobes.
module tb_ps2_frame_rx;
  import ps2_pkg::*;

  localparam int FL   = 4;
  localparam int TMO  = 400;
  localparam int HALF = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       code_valid, is_break, is_extended, parity_err, frame_err;

  ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ps2_clk     (ps2_clk),
    .i_ps2_data    (ps2_data),
    .o_code        (code),
    .o_code_valid  (code_valid),
    .o_is_break    (is_break),
    .o_is_extended (is_extended),
    .o_parity_err  (parity_err),
    .o_frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {EV_CODE, EV_PERR, EV_FERR} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] code;
    logic       brk;
    logic       ext;
    int         at;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  m_pend_break = 0;
  bit  m_pend_ext = 0;
  logic held_brk = 1'b0;
  logic held_ext = 1'b0;
  int  last_fall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one whole frame at a time, straight from the frame rules.
  task automatic model_frame(input logic [7:0] b, input bit par_bit, input bit stop_bit);
    ev_t e;
    e.code = b; e.brk = 0; e.ext = 0; e.at = -1;
    if (!stop_bit) begin
      e.kind = EV_FERR; exp_q.push_back(e);
      m_pend_break = 0; m_pend_ext = 0;
    end else if (($countones({b, par_bit}) % 2) == 0) begin
      e.kind = EV_PERR; exp_q.push_back(e);
      m_pend_break = 0; m_pend_ext = 0;
    end else if (b == 8'hF0) begin
      m_pend_break = 1;
    end else if (b == 8'hE0) begin
      m_pend_ext = 1;
    end else begin
      e.kind = EV_CODE; e.brk = m_pend_break; e.ext = m_pend_ext;
      exp_q.push_back(e);
      m_pend_break = 0; m_pend_ext = 0;
    end
  endtask

  task automatic drive_bit(input bit b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic clk_pulse(input int len);
    ps2_clk = 1'b0;
    repeat (len) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // first_bit=1 means a preceding long glitch already served as the start bit.
  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                            input int glitch_at, input int first_bit);
    logic [10:0] bits;
    bit par;
    par  = (~^b) ^ flip_par;
    bits = {~bad_stop, par, b, 1'b0};
    model_frame(b, par, ~bad_stop);
    for (int i = first_bit; i < 11; i++) begin
      if (i == glitch_at) begin
        repeat (4) @(negedge clk);
        clk_pulse(FL - 1);
      end
      drive_bit(bits[i]);
    end
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_code"}, code, 8'h00);
    check({tag, "_valid"}, code_valid, 1'b0);
    check({tag, "_break"}, is_break, 1'b0);
    check({tag, "_ext"}, is_extended, 1'b0);
    check({tag, "_perr"}, parity_err, 1'b0);
    check({tag, "_ferr"}, frame_err, 1'b0);
  endtask

  // Monitor: pops one expected event per DUT strobe, independent of the stimulus.
  always @(negedge clk) begin
    if (rst_n) begin
      if (code_valid || parity_err || frame_err) begin
        check("strobe_onehot", $countones({code_valid, parity_err, frame_err}), 1);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: got valid=%b perr=%b ferr=%b code=%0h, required none",
                   code_valid, parity_err, frame_err, code);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("strobe_kind", {code_valid, parity_err, frame_err},
                (e.kind == EV_CODE) ? 3'b100 : (e.kind == EV_PERR) ? 3'b010 : 3'b001);
          if (e.kind == EV_CODE) begin
            check("code", code, e.code);
            check("is_break", is_break, e.brk);
            check("is_extended", is_extended, e.ext);
            held_brk = e.brk;
            held_ext = e.ext;
          end
          if (e.at >= 0) check("timeout_cycle", cyc, e.at);
        end
      end else begin
        check("flag_hold", {is_break, is_extended}, {held_brk, held_ext});
      end
    end
  end

  initial begin
    ev_t e;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    send_frame(CLR, 0, 0, -1, 0);
    send_frame(8'hF0, 0, 0, -1, 0);
    send_frame(ADD, 0, 0, -1, 0);
    send_frame(8'hE0, 0, 0, -1, 0);
    send_frame(8'hF0, 0, 0, -1, 0);
    send_frame(8'h75, 0, 0, -1, 0);
    send_frame(8'hF0, 0, 0, -1, 0);
    send_frame(SUB, 1, 0, -1, 0);
    send_frame(SUB, 0, 0, -1, 0);
    send_frame(8'hF0, 0, 0, -1, 0);
    send_frame(8'hF0, 0, 0, -1, 0);
    send_frame(8'h1C, 0, 0, -1, 0);
    send_frame(8'h5A, 0, 1, -1, 0);

    // Short clock glitches in IDLE (with data low) and mid-DATA are ignored.
    ps2_data = 1'b0;
    repeat (4) @(negedge clk);
    clk_pulse(FL - 1);
    repeat (4) @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    send_frame(LOAD, 0, 0, -1, 0);
    send_frame(DISP, 0, 0, 4, 0);

    // A pulse one sample longer than the filter is a real start bit.
    ps2_data = 1'b0;
    repeat (HALF) @(negedge clk);
    clk_pulse(FL + 1);
    repeat (HALF) @(negedge clk);
    send_frame(ADD, 0, 0, -1, 1);

    // Timeout: pending break, then start + 4 data bits and silence.
    send_frame(8'hF0, 0, 0, -1, 0);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    ps2_data = 1'b1;
    e.kind = EV_FERR; e.code = 8'h00; e.brk = 0; e.ext = 0;
    e.at = last_fall + FL + TMO + 1;
    exp_q.push_back(e);
    m_pend_break = 0; m_pend_ext = 0;
    repeat (TMO + 50) @(negedge clk);
    send_frame(DISP, 0, 0, -1, 0);

    for (int n = 0; n < 50; n++) begin
      logic [7:0] b;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 8'hF0;
        1: b = 8'hE0;
        2: b = CLR;
        3: b = SUB;
        4: b = LOAD;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, -1, 0);
    end

    // Reset mid-frame with an extended prefix pending.
    send_frame(8'hE0, 0, 0, -1, 0);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rst_n = 1'b0;
    m_pend_break = 0; m_pend_ext = 0;
    held_brk = 1'b0; held_ext = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("midframe_reset");
    ps2_data = 1'b1;
    rst_n = 1'b1;
    repeat (TMO + 20) @(negedge clk);
    send_frame(CLR, 0, 0, -1, 0);

    repeat (100) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
